main_control_fsm: RTL and testbench
===================================

# main_control_fsm

Multi-cycle main controller for the 16-bit RISC core: it sequences each instruction through the IF, ID, EX, MEM and WB phases. It consumes the `opcode`, `mode` and branch-condition results produced by the decode and execute stages. It drives the stage enables, the decode steering controls (`RAsrc`, `RBsrc`, `regDst`, `ExtOp`) and the datapath controls used later in the instruction. It also keeps retired-instruction and cycle counters for bring-up.

## Interface
- Parameters:
- `CNT_W`, 16: width of the performance counters.
- Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `opcode` in 4: instruction bits [15:12]. The instruction register holds this value stable from the end of IF to the next IF.
- `mode` in 1: instruction mode bit, held stable the same way as `opcode`.
- `branch_cond` in 1: comparison result from EX. Valid only in EX.
- `enable_IF`, `enable_ID`, `enable_EX`, `enable_MEM`, `enable_WB` out 1 each: stage enables, exactly one high per cycle outside reset.
- `RAsrc` out 2: 00 selects the Rs1 field, 01 the Rd field, 10 R7.
- `RBsrc` out 1: 0 selects the Rs2 field, 1 the Rd field.
- `regDst` out 1: 0 writes Rd, 1 writes R7.
- `ExtOp` out 1: 1 sign-extend, 0 zero-extend.
- `ALUsrc` out 1: 0 selects BusB, 1 selects Imm16.
- `ALUop` out 2: 00 AND, 01 ADD, 10 SUB.
- `memRd`, `memWr`, `regWr` out 1 each: write/read strobes.
- `WBdata` out 2: 00 ALU, 01 memory, 10 nextPC.
- `PCsrc` out 2: 00 nextPC, 01 BTarget, 10 jumpTarget, 11 return address (BusA).
- `instr_count` out CNT_W: retired instructions.
- `cycle_count` out CNT_W: cycles since reset.

## Operation
- States: RST, IF, ID, EX, MEM, WB. State register is one-hot. Stage enables decode directly from the state register with no combinational path from inputs.
- Reset state is RST. The cycle after `reset` deasserts, the FSM moves RST→IF.
- In RST every output is 0 and both counters are 0. `reset` asserted in any state returns to RST on the next edge, abandoning the instruction in flight; no strobe fires in that cycle.
- IF→ID always. `PCsrc`=00 during IF, so the PC loads nextPC.
- Opcode map and state paths (decided; constants in package):
- 0 AND, 1 ADD, 2 SUB: ID→EX→WB. `RAsrc`=00, `RBsrc`=0, `ALUsrc`=0, `regWr` in WB, `WBdata`=00.
- 3 ADDI (ExtOp=1), 4 ANDI (ExtOp=0): ID→EX→WB with `ALUsrc`=1.
- 5 LW: ID→EX→MEM→WB. `ExtOp`=1, `ALUop`=ADD, `memRd` in MEM, `WBdata`=01.
- 6 LB: same path as LW. `mode`=0 is zero-extend, `mode`=1 is sign-extend; `ExtOp`=`mode`.
- 7 SW: ID→EX→MEM. `RBsrc`=1, `memWr` in MEM.
- 8–11 BGT, BLT, BEQ, BNE: ID→EX→IF. `ALUop`=SUB. `mode`=0 gives `RAsrc`=01 (compare Rd with Rs1); `mode`=1 gives `RAsrc`=01 with the zero-compare variant. `PCsrc`=01 in EX iff `branch_cond`, else 00.
- 12 JMP: ID→IF, `PCsrc`=10 in ID.
- 13 CALL: ID→IF. In ID, `PCsrc`=10, `regWr`=1, `regDst`=1, `WBdata`=10.
- 14 RET: ID→IF. `RAsrc`=10 and `PCsrc`=11 in ID.
- 15 Sv: ID→EX→MEM. `ALUsrc`=1, `memWr` in MEM.
- Outputs not named for a state are 0. Steering controls (`RAsrc`, `RBsrc`, `regDst`, `ExtOp`, `ALUsrc`, `ALUop`, `WBdata`) depend on `opcode`/`mode` only and may be held through the whole instruction.
- `instr_count` increments on the last state of each instruction path (retirement). `cycle_count` increments every non-RST cycle. Both wrap modulo 2^CNT_W.

## Timing
- Latency per instruction: R-type/I-type 4 cycles, loads 5, stores 4, branches 3, JMP/CALL/RET 2.
- `memRd`, `memWr`, `regWr` and `PCsrc`≠00 are single-cycle strobes. Each is asserted only in its named state.
- The first IF after reset is on cycle 2 after the reset-release edge.

## Structure
- Shared package `risc_pkg`: opcode constants, state enumeration, and the `RAsrc`, `PCsrc`, `WBdata` and `ALUop` encodings.
- The package is shared with the decode stage and the execute stage.
- One natural sub-module, `ctrl_decode`: combinational opcode/mode → steering controls. The FSM and counters stay in the top.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; `enable_IF`=1 two cycles after release; counters 0.
- ADD (opcode 1), then LW (opcode 5) → enable sequences IF,ID,EX,WB then IF,ID,EX,MEM,WB. `regWr` only in WB; `memRd` only in MEM; `instr_count`=2.
- BEQ with `branch_cond`=1, then with `branch_cond`=0 → `PCsrc`=01 for exactly one EX cycle in the first case only; 3 cycles each.
- CALL (opcode 13) → in ID: `PCsrc`=10, `regWr`=1, `regDst`=1, `WBdata`=10; next state IF.
- `reset` asserted during MEM of SW → no `memWr` pulse; FSM in RST next cycle.
- Run 65,536 cycles of JMP loops → `cycle_count` wraps to 0 and `instr_count` wraps consistently.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: opcodes, controller states,
// and the encodings of the datapath steering and PC/write-back selects.
package risc_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_ANDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_LB   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BGT  = 4'd8;
  localparam logic [3:0] OP_BLT  = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_CALL = 4'd13;
  localparam logic [3:0] OP_RET  = 4'd14;
  localparam logic [3:0] OP_SV   = 4'd15;

  // One-hot controller states.
  typedef enum logic [5:0] {
    ST_RST = 6'b000001,
    ST_IF  = 6'b000010,
    ST_ID  = 6'b000100,
    ST_EX  = 6'b001000,
    ST_MEM = 6'b010000,
    ST_WB  = 6'b100000
  } state_e;

  typedef enum logic [1:0] {RA_RS1 = 2'b00, RA_RD = 2'b01, RA_R7 = 2'b10} ra_src_e;
  typedef enum logic [1:0] {PC_NEXT = 2'b00, PC_BTARGET = 2'b01, PC_JUMP = 2'b10, PC_RET = 2'b11} pc_src_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_NEXTPC = 2'b10} wb_data_e;
  typedef enum logic [1:0] {ALU_AND = 2'b00, ALU_ADD = 2'b01, ALU_SUB = 2'b10} alu_op_e;

  // Instruction classes: each class has its own state path.
  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JMP, CLS_CALL, CLS_RET
  } instr_cls_e;

  typedef struct packed {
    ra_src_e  ra_src;
    logic     rb_src;
    logic     reg_dst;
    logic     ext_op;
    logic     alu_src;
    alu_op_e  alu_op;
    wb_data_e wb_data;
  } steer_t;

  localparam steer_t STEER_NONE = '{RA_RS1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_AND, WB_ALU};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/mode decode: steering controls held for the whole
// instruction plus the instruction class that picks the state path.
module ctrl_decode
  import risc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       mode,
  output steer_t     steer,
  output instr_cls_e cls
);

  // Map each opcode to its steering controls and state-path class.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    steer = STEER_NONE;
    cls   = CLS_ALU;
    case (opcode)
      OP_AND:  steer.alu_op = ALU_AND;
      OP_ADD:  steer.alu_op = ALU_ADD;
      OP_SUB:  steer.alu_op = ALU_SUB;
      OP_ADDI: begin
        steer.ext_op  = 1'b1;
        steer.alu_src = 1'b1;
        steer.alu_op  = ALU_ADD;
      end
      OP_ANDI: steer.alu_src = 1'b1;
      OP_LW, OP_LB: begin
        // LB picks the extension from the mode bit; LW always sign-extends.
        steer.ext_op  = (opcode == OP_LB) ? mode : 1'b1;
        steer.alu_src = 1'b1;
        steer.alu_op  = ALU_ADD;
        steer.wb_data = WB_MEM;
        cls           = CLS_LOAD;
      end
      OP_SW: begin
        // Store data comes from the Rd field on port B.
        steer.rb_src  = 1'b1;
        steer.ext_op  = 1'b1;
        steer.alu_src = 1'b1;
        steer.alu_op  = ALU_ADD;
        cls           = CLS_STORE;
      end
      OP_BGT, OP_BLT, OP_BEQ, OP_BNE: begin
        steer.ra_src = RA_RD;
        steer.alu_op = ALU_SUB;
        cls          = CLS_BRANCH;
      end
      OP_JMP:  cls = CLS_JMP;
      OP_CALL: begin
        steer.reg_dst = 1'b1;
        steer.wb_data = WB_NEXTPC;
        cls           = CLS_CALL;
      end
      OP_RET: begin
        steer.ra_src = RA_R7;
        cls          = CLS_RET;
      end
      OP_SV: begin
        steer.alu_src = 1'b1;
        cls           = CLS_STORE;
      end
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main controller: steps each instruction through IF/ID/EX/MEM/WB,
// drives stage enables, strobes and steering, and keeps bring-up counters.
module main_control_fsm
  import risc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             mode,
  input  logic             branch_cond,
  output logic             enable_IF,
  output logic             enable_ID,
  output logic             enable_EX,
  output logic             enable_MEM,
  output logic             enable_WB,
  output logic [1:0]       RAsrc,
  output logic             RBsrc,
  output logic             regDst,
  output logic             ExtOp,
  output logic             ALUsrc,
  output logic [1:0]       ALUop,
  output logic             memRd,
  output logic             memWr,
  output logic             regWr,
  output logic [1:0]       WBdata,
  output logic [1:0]       PCsrc,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic             retire;
  logic             active;
  steer_t           steer;
  instr_cls_e       cls;

  ctrl_decode u_ctrl_decode (
    .opcode (opcode),
    .mode   (mode),
    .steer  (steer),
    .cls    (cls)
  );

  // Next state, retirement on the last state of each path, counter updates.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_IF;
      ST_IF:  state_d = ST_ID;
      ST_ID: begin
        if (cls inside {CLS_JMP, CLS_CALL, CLS_RET}) begin
          state_d = ST_IF;
          retire  = 1'b1;
        end else begin
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        case (cls)
          CLS_BRANCH: begin
            state_d = ST_IF;
            retire  = 1'b1;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (cls == CLS_STORE) begin
          state_d = ST_IF;
          retire  = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        state_d = ST_IF;
        retire  = 1'b1;
      end
      default: state_d = ST_RST;
    endcase
    instr_d = retire ? instr_q + CNT_W'(1) : instr_q;
    cycle_d = (state_q != ST_RST) ? cycle_q + CNT_W'(1) : cycle_q;
  end

  // State register and counters with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q <= ST_RST;
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      cycle_q <= cycle_d;
    end
  end

  assign enable_IF  = (state_q == ST_IF);
  assign enable_ID  = (state_q == ST_ID);
  assign enable_EX  = (state_q == ST_EX);
  assign enable_MEM = (state_q == ST_MEM);
  assign enable_WB  = (state_q == ST_WB);

  // Steering is forced to 0 in RST and while reset is asserted.
  assign active = !reset && (state_q != ST_RST);

  assign RAsrc  = active ? steer.ra_src  : 2'b00;
  assign RBsrc  = active && steer.rb_src;
  assign regDst = active && steer.reg_dst;
  assign ExtOp  = active && steer.ext_op;
  assign ALUsrc = active && steer.alu_src;
  assign ALUop  = active ? steer.alu_op  : 2'b00;
  assign WBdata = active ? steer.wb_data : 2'b00;

  // Single-cycle strobes, suppressed in a cycle where reset abandons the instruction.
  always_comb begin
    memRd = !reset && enable_MEM && (cls == CLS_LOAD);
    memWr = !reset && enable_MEM && (cls == CLS_STORE);
    regWr = !reset && (enable_WB || (enable_ID && cls == CLS_CALL));
    PCsrc = PC_NEXT;
    if (!reset) begin
      if (enable_ID && (cls == CLS_JMP || cls == CLS_CALL)) PCsrc = PC_JUMP;
      else if (enable_ID && cls == CLS_RET)                 PCsrc = PC_RET;
      else if (enable_EX && cls == CLS_BRANCH && branch_cond) PCsrc = PC_BTARGET;
    end
  end

  assign instr_count = instr_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: directed scenarios plus random
// instruction streams checked against a per-instruction path/strobe model.
module tb_main_control_fsm;

  localparam int CNT_W = 16;
  localparam int S_IF = 0, S_ID = 1, S_EX = 2, S_MEM = 3, S_WB = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       opcode = 4'd0;
  logic             mode = 1'b0;
  logic             branch_cond = 1'b0;
  logic             enable_IF, enable_ID, enable_EX, enable_MEM, enable_WB;
  logic [1:0]       RAsrc, ALUop, WBdata, PCsrc;
  logic             RBsrc, regDst, ExtOp, ALUsrc, memRd, memWr, regWr;
  logic [CNT_W-1:0] instr_count, cycle_count;

  int errors = 0;
  int checks = 0;
  int exp_cycles = 0;
  int exp_retired = 0;

  main_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mode(mode), .branch_cond(branch_cond),
    .enable_IF(enable_IF), .enable_ID(enable_ID), .enable_EX(enable_EX),
    .enable_MEM(enable_MEM), .enable_WB(enable_WB),
    .RAsrc(RAsrc), .RBsrc(RBsrc), .regDst(regDst), .ExtOp(ExtOp), .ALUsrc(ALUsrc),
    .ALUop(ALUop), .memRd(memRd), .memWr(memWr), .regWr(regWr), .WBdata(WBdata),
    .PCsrc(PCsrc), .instr_count(instr_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] enables_v();
    return {enable_WB, enable_MEM, enable_EX, enable_ID, enable_IF};
  endfunction

  function automatic logic [4:0] strobes_v();
    return {memRd, memWr, regWr, PCsrc};
  endfunction

  function automatic logic [9:0] steer_v();
    return {RAsrc, RBsrc, regDst, ExtOp, ALUsrc, ALUop, WBdata};
  endfunction

  // Number of cycles the instruction occupies.
  function automatic int path_len(input int op);
    if (op <= 4)                return 4;
    if (op == 5 || op == 6)     return 5;
    if (op == 7 || op == 15)    return 4;
    if (op >= 8 && op <= 11)    return 3;
    return 2;
  endfunction

  // Stage visited at position i of the instruction's path.
  function automatic int stage_of(input int op, input int i);
    if (i < 3)  return i;
    if (i == 3) return (op <= 4) ? S_WB : S_MEM;
    return S_WB;
  endfunction

  // Steering table: {RAsrc, RBsrc, regDst, ExtOp, ALUsrc, ALUop, WBdata}.
  function automatic logic [9:0] exp_steer(input int op, input bit md);
    logic [1:0] ra = 2'd0, aluop = 2'd0, wb = 2'd0;
    logic       rb = 1'b0, rd = 1'b0, ext = 1'b0, src = 1'b0;
    case (op)
      1:  aluop = 2'd1;
      2:  aluop = 2'd2;
      3:  begin ext = 1'b1; src = 1'b1; aluop = 2'd1; end
      4:  src = 1'b1;
      5:  begin ext = 1'b1; src = 1'b1; aluop = 2'd1; wb = 2'd1; end
      6:  begin ext = md;   src = 1'b1; aluop = 2'd1; wb = 2'd1; end
      7:  begin rb = 1'b1; ext = 1'b1; src = 1'b1; aluop = 2'd1; end
      8, 9, 10, 11: begin ra = 2'd1; aluop = 2'd2; end
      13: begin rd = 1'b1; wb = 2'd2; end
      14: ra = 2'd2;
      15: src = 1'b1;
      default: ;
    endcase
    return {ra, rb, rd, ext, src, aluop, wb};
  endfunction

  // Strobes {memRd, memWr, regWr, PCsrc} expected in a given stage.
  function automatic logic [4:0] exp_strobes(input int op, input int st, input bit bc);
    logic       rdm = (st == S_MEM) && (op == 5 || op == 6);
    logic       wrm = (st == S_MEM) && (op == 7 || op == 15);
    logic       rw  = (st == S_WB) || (st == S_ID && op == 13);
    logic [1:0] pc  = 2'd0;
    if (st == S_ID && (op == 12 || op == 13)) pc = 2'd2;
    if (st == S_ID && op == 14)               pc = 2'd3;
    if (st == S_EX && op >= 8 && op <= 11 && bc) pc = 2'd1;
    return {rdm, wrm, rw, pc};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},    32'(enables_v()), 32'd0);
    check({tag, "_strb"},  32'(strobes_v()), 32'd0);
    check({tag, "_steer"}, 32'(steer_v()),   32'd0);
    check({tag, "_icnt"},  32'(instr_count), 32'd0);
    check({tag, "_ccnt"},  32'(cycle_count), 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check_all_zero("in_reset");
    end
    reset = 1'b0;
    #1;
    check_all_zero("rst_state");
    exp_cycles  = 0;
    exp_retired = 0;
  endtask

  // Runs one instruction, checking every cycle; optionally asserts reset in MEM.
  task automatic do_instr(input int op, input bit md, input bit bc, input bit abort_mem);
    int n = path_len(op);
    for (int i = 0; i < n; i++) begin
      int  st = stage_of(op, i);
      bit  kill;
      @(negedge clk);
      if (i == 0) begin
        opcode      = op[3:0];
        mode        = md;
        branch_cond = bc;
        #1;
      end
      kill = abort_mem && (st == S_MEM);
      if (kill) begin
        reset = 1'b1;
        #1;
      end
      check("enables", 32'(enables_v()), 32'(1 << st));
      check("strobes", 32'(strobes_v()), kill ? 32'd0 : 32'(exp_strobes(op, st, bc)));
      if (i > 0)
        check("steer", 32'(steer_v()), kill ? 32'd0 : 32'(exp_steer(op, md)));
      check("cycle_count", 32'(cycle_count), 32'(exp_cycles % (1 << CNT_W)));
      check("instr_count", 32'(instr_count), 32'(exp_retired % (1 << CNT_W)));
      if (kill) begin
        @(negedge clk);
        check_all_zero("after_abort");
        reset = 1'b0;
        #1;
        check_all_zero("abort_release");
        exp_cycles  = 0;
        exp_retired = 0;
        return;
      end
      exp_cycles++;
      if (i == n - 1) exp_retired++;
    end
  endtask

  initial begin
    do_reset(3);

    // ADD then LW.
    do_instr(1, 1'b0, 1'b0, 1'b0);
    do_instr(5, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("instr_after_add_lw", 32'(instr_count), 32'd2);

    // BEQ taken then not taken, CALL, LB both modes.
    do_instr(10, 1'b0, 1'b1, 1'b0);
    do_instr(10, 1'b1, 1'b0, 1'b0);
    do_instr(13, 1'b0, 1'b0, 1'b0);
    do_instr(6, 1'b0, 1'b0, 1'b0);
    do_instr(6, 1'b1, 1'b0, 1'b0);
    do_instr(14, 1'b0, 1'b0, 1'b0);

    // Reset during MEM of SW: no memWr, RST next cycle.
    do_instr(7, 1'b0, 1'b0, 1'b1);
    do_instr(15, 1'b0, 1'b0, 1'b0);

    // Random instruction stream.
    for (int k = 0; k < 400; k++)
      do_instr(int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)), 1'b0);

    // 65,536 cycles of JMP from a fresh reset: cycle counter wraps to 0.
    do_reset(2);
    for (int k = 0; k < 32768; k++)
      do_instr(12, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("cycle_wrap", 32'(cycle_count), 32'd0);
    check("instr_after_loop", 32'(instr_count), 32'd32768);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
